// File: rtl/id_regfile_sb_pkg.sv
// Shared constants for the ID-stage register file and scoreboard.
// Also provides the slice macro for the flattened multi-port buses.
package id_regfile_sb_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;
   localparam int DEF_PEND_W = 2;
   localparam int REG_ZERO   = 0;

   // Largest value a pending-write counter of the given width can hold.
   function automatic int pend_max(input int pend_w);
      return (1 << pend_w) - 1;
   endfunction

endpackage

`ifndef IDRF_SLICE
`define IDRF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

// File: rtl/id_regfile_sb_if.sv
// Decode/writeback-facing bundle of the ID-stage register file.
// The master side is decode plus writeback; the slave side is the register file.
interface id_regfile_sb_if
   import id_regfile_sb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
) ();

   logic [NUM_RD*ADDR_W-1:0] Read_Address_ID;
   logic [NUM_RD*DATA_W-1:0] Read_Data_ID;
   logic [NUM_RD-1:0]        Read_Busy_ID;
   logic                     Issue_Valid_ID;
   logic [ADDR_W-1:0]        Issue_Register_ID;
   logic                     Issue_Ready_ID;
   logic [ADDR_W-1:0]        Write_Register_WB;
   logic [DATA_W-1:0]        Write_Data_WB;
   logic                     RegWrite_WB;
   logic                     Sb_Error;

   modport master (
      output Read_Address_ID,
      output Issue_Valid_ID,
      output Issue_Register_ID,
      output Write_Register_WB,
      output Write_Data_WB,
      output RegWrite_WB,
      input  Read_Data_ID,
      input  Read_Busy_ID,
      input  Issue_Ready_ID,
      input  Sb_Error
   );

   modport slave (
      input  Read_Address_ID,
      input  Issue_Valid_ID,
      input  Issue_Register_ID,
      input  Write_Register_WB,
      input  Write_Data_WB,
      input  RegWrite_WB,
      output Read_Data_ID,
      output Read_Busy_ID,
      output Issue_Ready_ID,
      output Sb_Error
   );

endinterface

// File: rtl/id_regfile_sb_counter.sv
// Per-register pending-write counter: issued-but-uncommitted writes to one register.
// Saturation blocks increment and zero blocks decrement, so the count never wraps.
module id_sb_counter
   import id_regfile_sb_pkg::*;
#(
   parameter int PEND_W = DEF_PEND_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              inc,
   input  logic              dec,
   output logic [PEND_W-1:0] cnt,
   output logic              sat,
   output logic              zero
);

   localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_max(PEND_W));

   logic inc_ok;
   logic dec_ok;

   assign sat    = (cnt == CNT_MAX);
   assign zero   = (cnt == '0);
   assign inc_ok = inc && !sat;
   assign dec_ok = dec && !zero;

   // A simultaneous issue and commit cancel out.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         cnt <= '0;
      end else if (inc_ok && !dec_ok) begin
         cnt <= cnt + PEND_W'(1);
      end else if (dec_ok && !inc_ok) begin
         cnt <= cnt - PEND_W'(1);
      end
   end

endmodule

// File: rtl/id_regfile_sb.sv
// ID-stage register file: NUM_RD combinational reads, one WB write, optional WB->ID bypass,
// and a per-register pending-write scoreboard that drives per-port busy flags and issue ready.
module id_regfile_sb
   import id_regfile_sb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD,
   parameter int BYPASS = 1,
   parameter int PEND_W = DEF_PEND_W
) (
   input  logic           Clk,
   input  logic           Rst,
   id_regfile_sb_if.slave rf_if
);

   localparam int                NREG   = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] rf      [NREG];
   logic [PEND_W-1:0] cnt     [NREG];
   logic [NREG-1:0]   sat_v;
   logic [NREG-1:0]   zero_v;
   logic              wb_en;
   logic              sb_err;

   assign wb_en = rf_if.RegWrite_WB && (rf_if.Write_Register_WB != ZERO_A);

   // Register 0 has no counter; it looks permanently idle.
   assign cnt[0]    = '0;
   assign sat_v[0]  = 1'b0;
   assign zero_v[0] = 1'b1;

   for (genvar r = 1; r < NREG; r++) begin : g_cnt
      logic inc;
      logic dec;

      assign inc = rf_if.Issue_Valid_ID && rf_if.Issue_Ready_ID
                   && (rf_if.Issue_Register_ID == ADDR_W'(r));
      assign dec = rf_if.RegWrite_WB && (rf_if.Write_Register_WB == ADDR_W'(r));

      id_sb_counter #(
         .PEND_W (PEND_W)
      ) u_cnt (
         .Clk  (Clk),
         .Rst  (Rst),
         .inc  (inc),
         .dec  (dec),
         .cnt  (cnt[r]),
         .sat  (sat_v[r]),
         .zero (zero_v[r])
      );
   end

   // Ready looks only at the stored count, so there is no WB-to-issue timing path.
   assign rf_if.Issue_Ready_ID = (rf_if.Issue_Register_ID == ZERO_A)
                                 || !sat_v[rf_if.Issue_Register_ID];

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int k = 0; k < NREG; k++) begin
            rf[k] <= '0;
         end
      end else if (wb_en) begin
         rf[rf_if.Write_Register_WB] <= rf_if.Write_Data_WB;
      end
   end

   // A commit with nothing pending is a pipeline bookkeeping bug; remember it until reset.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         sb_err <= 1'b0;
      end else if (wb_en && zero_v[rf_if.Write_Register_WB]) begin
         sb_err <= 1'b1;
      end
   end

   assign rf_if.Sb_Error = sb_err;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      logic              wb_hit;

      assign rd_addr = `IDRF_SLICE(rf_if.Read_Address_ID, i, ADDR_W);
      assign wb_hit  = (BYPASS != 0) && !Rst && rf_if.RegWrite_WB
                       && (rf_if.Write_Register_WB == rd_addr);

      assign `IDRF_SLICE(rf_if.Read_Data_ID, i, DATA_W) =
         (rd_addr == ZERO_A) ? '0 :
         wb_hit              ? rf_if.Write_Data_WB :
                               rf[rd_addr];

      // The last outstanding write landing this cycle is forwarded, so it no longer stalls.
      assign rf_if.Read_Busy_ID[i] = (rd_addr != ZERO_A) && !zero_v[rd_addr]
                                     && !(wb_hit && (cnt[rd_addr] == PEND_W'(1)));
   end

endmodule
